// File: rtl/axi_dma_pkg.sv
// Shared types and constants for the DMA channel scheduler and its engine interface.
package axi_dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_e;

  // AXI BRESP/RRESP encodings seen by the engine
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_LEN_WIDTH  = 16;

endpackage

// File: rtl/axi_dma_chan_sched_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or above rr_ptr
// (wrapping to 0) wins.
module rr_arbiter #(
  parameter int NUM_CH = 4,
  localparam int CH_W = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   rr_ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   grant_idx,
  output logic              grant_valid
);

  function automatic logic [CH_W-1:0] wrap_idx(input logic [CH_W-1:0] base, input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= 32'(NUM_CH)) begin
      sum = sum - 32'(NUM_CH);
    end
    return sum[CH_W-1:0];
  endfunction

  // Scan from the far end back toward rr_ptr so the nearest requester is written last.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (req[wrap_idx(rr_ptr, 32'(k))]) begin
        grant_idx   = wrap_idx(rr_ptr, 32'(k));
        grant_valid = 1'b1;
      end else begin
        grant_idx   = grant_idx;
      end
    end
    if (grant_valid) begin
      grant[grant_idx] = 1'b1;
    end else begin
      grant = '0;
    end
  end

endmodule

// File: rtl/axi_dma_chan_sched.sv
// Round-robin scheduler sharing one DMA engine among NUM_CH channel requesters:
// accepts a descriptor, issues one engine command, reports done/error per channel.
module axi_dma_chan_sched
  import axi_dma_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int LEN_WIDTH      = DEF_LEN_WIDTH,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int CH_W  = $clog2(NUM_CH),
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_CH-1:0]            req_valid,
  output logic [NUM_CH-1:0]            req_ready,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] req_src,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] req_dst,
  input  logic [NUM_CH*LEN_WIDTH-1:0]  req_len,
  output logic [NUM_CH-1:0]            ch_done,
  output logic [NUM_CH-1:0]            ch_err,
  output logic                         cmd_valid,
  input  logic                         cmd_ready,
  output logic [ADDR_WIDTH-1:0]        cmd_src,
  output logic [ADDR_WIDTH-1:0]        cmd_dst,
  output logic [LEN_WIDTH-1:0]         cmd_len,
  input  logic                         eng_done,
  input  logic                         eng_err,
  output logic                         eng_abort,
  output logic                         busy,
  output logic [CH_W-1:0]              active_ch
);

  sched_state_e          state_r, state_nxt_s;
  logic [CH_W-1:0]       rr_ptr_r, active_ch_r, grant_idx_s, done_ch_s;
  logic [NUM_CH-1:0]     grant_s, ch_done_r, ch_err_r;
  logic                  grant_valid_s, timeout_s, done_err_s, cmd_valid_r;
  logic [CNT_W-1:0]      cnt_r;
  logic [ADDR_WIDTH-1:0] sel_src_s, sel_dst_s, cmd_src_r, cmd_dst_r;
  logic [LEN_WIDTH-1:0]  sel_len_s, cmd_len_r;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req         (req_valid),
    .rr_ptr      (rr_ptr_r),
    .grant       (grant_s),
    .grant_idx   (grant_idx_s),
    .grant_valid (grant_valid_s)
  );

  assign sel_src_s = req_src[grant_idx_s * ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_dst_s = req_dst[grant_idx_s * ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_len_s = req_len[grant_idx_s * LEN_WIDTH +: LEN_WIDTH];

  // Abort is decided in the same cycle as eng_done so a late completion still wins.
  assign timeout_s = (state_r == ST_WAIT) && !eng_done && (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

  assign eng_abort = timeout_s;
  assign busy      = (state_r != ST_IDLE);
  assign active_ch = active_ch_r;
  assign cmd_valid = cmd_valid_r;
  assign cmd_src   = cmd_src_r;
  assign cmd_dst   = cmd_dst_r;
  assign cmd_len   = cmd_len_r;
  assign ch_done   = ch_done_r;
  assign ch_err    = ch_err_r;

  // Grant is only offered in IDLE and never while reset is held.
  always_comb begin
    req_ready = '0;
    if (reset_n && (state_r == ST_IDLE)) begin
      req_ready = grant_s;
    end else begin
      req_ready = '0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_valid_s) begin
          state_nxt_s = (sel_len_s == '0) ? ST_DONE : ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (cmd_ready) begin
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (eng_done || timeout_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Which channel and error status the upcoming DONE cycle reports.
  always_comb begin
    done_ch_s  = active_ch_r;
    done_err_s = 1'b0;
    if (state_r == ST_IDLE) begin
      done_ch_s  = grant_idx_s;
      done_err_s = 1'b0;
    end else if (state_r == ST_WAIT) begin
      done_ch_s  = active_ch_r;
      done_err_s = eng_done ? eng_err : 1'b1;
    end else begin
      done_ch_s  = active_ch_r;
      done_err_s = 1'b0;
    end
  end

  // Descriptor latch, command handshake, timeout counter and completion pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_r    <= '0;
      active_ch_r <= '0;
      cnt_r       <= '0;
      cmd_valid_r <= 1'b0;
      cmd_src_r   <= '0;
      cmd_dst_r   <= '0;
      cmd_len_r   <= '0;
      ch_done_r   <= '0;
      ch_err_r    <= '0;
    end else begin
      ch_done_r <= '0;
      ch_err_r  <= '0;
      if (state_nxt_s == ST_DONE) begin
        ch_done_r[done_ch_s] <= 1'b1;
        ch_err_r[done_ch_s]  <= done_err_s;
      end
      case (state_r)
        ST_IDLE: begin
          if (grant_valid_s) begin
            active_ch_r <= grant_idx_s;
            cmd_src_r   <= sel_src_s;
            cmd_dst_r   <= sel_dst_s;
            cmd_len_r   <= sel_len_s;
            cmd_valid_r <= (sel_len_s != '0);
          end
        end
        ST_ISSUE: begin
          if (cmd_ready) begin
            cmd_valid_r <= 1'b0;
            cnt_r       <= '0;
          end
        end
        ST_WAIT: cnt_r <= cnt_r + CNT_W'(1);
        ST_DONE: rr_ptr_r <= (active_ch_r == CH_W'(NUM_CH - 1)) ? '0 : active_ch_r + CH_W'(1);
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_dma_chan_sched.sv
// Self-checking bench for axi_dma_chan_sched: directed scenarios plus randomized
// traffic compared against a transaction-level round-robin reference model.
module tb_axi_dma_chan_sched;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int LW = 16;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready, ch_done, ch_err;
  logic [N*AW-1:0] req_src = '0, req_dst = '0;
  logic [N*LW-1:0] req_len = '0;
  logic            cmd_valid, eng_abort, busy;
  logic            cmd_ready = 1'b0, eng_done = 1'b0, eng_err = 1'b0;
  logic [AW-1:0]   cmd_src, cmd_dst;
  logic [LW-1:0]   cmd_len;
  logic [1:0]      active_ch;

  int checks = 0;
  int errors = 0;

  // requester-side model: pending descriptors and the expected round-robin pointer
  bit            pend [N];
  logic [AW-1:0] d_src [N];
  logic [AW-1:0] d_dst [N];
  logic [LW-1:0] d_len [N];
  int            rr_ptr = 0;

  always #5 clk = ~clk;

  axi_dma_chan_sched #(.NUM_CH(N), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_src(req_src), .req_dst(req_dst), .req_len(req_len), .ch_done(ch_done), .ch_err(ch_err),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_src(cmd_src), .cmd_dst(cmd_dst),
    .cmd_len(cmd_len), .eng_done(eng_done), .eng_err(eng_err), .eng_abort(eng_abort),
    .busy(busy), .active_ch(active_ch)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req();
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = pend[i];
      req_src[i*AW +: AW]   = d_src[i];
      req_dst[i*AW +: AW]   = d_dst[i];
      req_len[i*LW +: LW]   = d_len[i];
    end
  endtask

  task automatic set_desc(input int ch, input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [LW-1:0] l);
    pend[ch]  = 1'b1;
    d_src[ch] = s;
    d_dst[ch] = d;
    d_len[ch] = l;
  endtask

  task automatic rand_desc(input int ch, input bit allow_zero);
    logic [LW-1:0] l;
    l = LW'($urandom_range(1, 16'hffff));
    if (allow_zero && ($urandom_range(0, 3) == 0)) l = '0;
    set_desc(ch, AW'($urandom), AW'($urandom), l);
  endtask

  function automatic int predict();
    for (int k = 0; k < N; k++) begin
      if (pend[(rr_ptr + k) % N]) return (rr_ptr + k) % N;
    end
    return 0;
  endfunction

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic bit any_pend();
    for (int i = 0; i < N; i++) if (pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  // One full transaction starting in an IDLE cycle. dly<0 means the engine never answers.
  task automatic serve(input int bp, input int dly, input bit err, input bit reload);
    int w;
    int n;
    bit seen;
    logic [AW-1:0] es, ed;
    logic [LW-1:0] el;
    drive_req();
    #1;
    w  = predict();
    es = d_src[w];
    ed = d_dst[w];
    el = d_len[w];
    check("idle_busy", busy, 0);
    check("grant", req_ready, oh(w));
    next_cycle();
    if (reload) rand_desc(w, 1'b0);
    else pend[w] = 1'b0;
    drive_req();
    #1;
    check("busy_accept", busy, 1);
    check("active_ch", active_ch, w);
    check("ready_busy", req_ready, 0);
    if (el == '0) begin
      check("zl_cmd_valid", cmd_valid, 0);
      check("zl_done", ch_done, oh(w));
      check("zl_err", ch_err, 0);
    end else begin
      check("early_done", ch_done, 0);
      for (int i = 0; i <= bp; i++) begin
        if (i > 0) next_cycle();
        cmd_ready = (i == bp);
        #1;
        check("cmd_valid", cmd_valid, 1);
        check("cmd_src", cmd_src, es);
        check("cmd_dst", cmd_dst, ed);
        check("cmd_len", cmd_len, el);
      end
      next_cycle();
      cmd_ready = 1'b0;
      #1;
      check("cmd_valid_drop", cmd_valid, 0);
      if (dly >= 0) begin
        for (int i = 0; i <= dly; i++) begin
          if (i > 0) next_cycle();
          eng_done = (i == dly);
          eng_err  = err && (i == dly);
          #1;
          check("no_abort", eng_abort, 0);
          check("wait_no_done", ch_done, 0);
        end
        next_cycle();
        eng_done = 1'b0;
        eng_err  = 1'b0;
        #1;
        check("done", ch_done, oh(w));
        check("err", ch_err, err ? oh(w) : '0);
      end else begin
        n = 0;
        seen = 1'b0;
        for (int i = 1; i <= 64 && !seen; i++) begin
          if (i > 1) begin
            next_cycle();
            #1;
          end
          if (eng_abort) begin
            seen = 1'b1;
            n = i;
          end
        end
        check("abort_seen", seen, 1);
        check("abort_cycle", n, TO);
        next_cycle();
        #1;
        check("abort_pulse", eng_abort, 0);
        check("to_done", ch_done, oh(w));
        check("to_err", ch_err, oh(w));
      end
    end
    rr_ptr = (w + 1) % N;
    next_cycle();
    #1;
    check("idle_after", busy, 0);
    check("done_pulse", ch_done, 0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; d_src[i] = '0; d_dst[i] = '0; d_len[i] = '0;
    end
    // reset state, with a request already pending
    set_desc(0, 32'h0000_00aa, 32'h0000_00bb, 16'h0004);
    drive_req();
    #12;
    check("rst_ready", req_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_cmd_src", cmd_src, 0);
    check("rst_active", active_ch, 0);
    check("rst_done", ch_done, 0);
    check("rst_abort", eng_abort, 0);
    pend[0] = 1'b0;
    drive_req();
    next_cycle();
    reset_n = 1'b1;
    next_cycle();

    // single request on ch1, engine answers 5 cycles after the command handshake
    set_desc(1, 32'h0000_1000, 32'h0000_2000, 16'h0040);
    serve(0, 4, 1'b0, 1'b0);

    // round robin with all channels continuously requesting, 3 transfers each
    for (int c = 0; c < N; c++) rand_desc(c, 1'b0);
    for (int t = 0; t < 3 * N; t++) serve($urandom_range(0, 2), $urandom_range(0, 4), 1'b0, t < 2 * N);

    // backpressure: cmd_ready low for 7 cycles
    set_desc(3, 32'hdead_0000, 32'hbeef_0000, 16'h0100);
    serve(7, 2, 1'b0, 1'b0);

    // engine error on ch2, then ch3 must win over ch0
    set_desc(2, 32'h0000_3000, 32'h0000_4000, 16'h0020);
    serve(0, 3, 1'b1, 1'b0);
    rand_desc(0, 1'b0);
    rand_desc(3, 1'b0);
    check("rr_after_err", predict(), 3);
    serve(0, 1, 1'b0, 1'b0);
    serve(0, 1, 1'b0, 1'b0);

    // timeout, then eng_done landing exactly on the timeout cycle
    rand_desc(1, 1'b0);
    serve(2, -1, 1'b0, 1'b0);
    rand_desc(2, 1'b0);
    serve(0, TO - 1, 1'b0, 1'b0);
    rand_desc(3, 1'b0);
    serve(0, TO - 1, 1'b1, 1'b0);

    // zero-length descriptor
    set_desc(0, 32'h0000_5000, 32'h0000_6000, 16'h0000);
    serve(0, 0, 1'b0, 1'b0);

    // randomized traffic
    for (int it = 0; it < 24; it++) begin
      for (int c = 0; c < N; c++) if (!pend[c] && $urandom_range(0, 1) == 1) rand_desc(c, 1'b1);
      if (any_pend()) serve($urandom_range(0, 3), ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 10),
                            1'($urandom_range(0, 1)), 1'b0);
    end
    for (int k = 0; k < N && any_pend(); k++) serve(0, 1, 1'b0, 1'b0);

    // reset asserted during WAIT drops the transfer silently
    set_desc(1, 32'h0000_7000, 32'h0000_8000, 16'h0010);
    drive_req();
    next_cycle();
    pend[1] = 1'b0;
    drive_req();
    cmd_ready = 1'b1;
    next_cycle();
    cmd_ready = 1'b0;
    next_cycle();
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cmd_valid", cmd_valid, 0);
    check("mid_rst_cmd_len", cmd_len, 0);
    check("mid_rst_active", active_ch, 0);
    check("mid_rst_abort", eng_abort, 0);
    next_cycle();
    reset_n = 1'b1;
    rr_ptr = 0;
    for (int i = 0; i < 5; i++) begin
      eng_done = (i == 0);
      eng_err  = (i == 0);
      #1;
      check("post_rst_done", ch_done, 0);
      check("post_rst_busy", busy, 0);
      next_cycle();
    end
    eng_done = 1'b0;
    eng_err  = 1'b0;
    set_desc(2, 32'h0000_9000, 32'h0000_a000, 16'h0008);
    serve(1, 2, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_dma_chan_sched.md
Name: axi_dma_chan_sched

Overview:
- Round-robin scheduler that shares one axi_dma_controller engine between NUM_CH DMA channel requesters.
- Accepts one descriptor (src, dst, len) per channel request and issues it to the engine as a single command.
- Waits for engine completion or timeout, then returns a per-channel done/error pulse.
- Sits between the channel register front-ends and the engine's command/status interface.

Parameters:
- NUM_CH, 4, number of requesting channels (2..8).
- ADDR_WIDTH, 32, source/destination byte address width.
- LEN_WIDTH, 16, transfer length in bytes.
- TIMEOUT_CYCLES, 1024, cycles allowed in WAIT before abort.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_CH  per-channel request; held until accepted.
- req_ready  out  NUM_CH  one-hot accept.
- req_src  in  NUM_CH*ADDR_WIDTH  packed source addresses; channel i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_dst  in  NUM_CH*ADDR_WIDTH  packed destination addresses.
- req_len  in  NUM_CH*LEN_WIDTH  packed byte lengths.
- ch_done  out  NUM_CH  one-cycle completion pulse.
- ch_err  out  NUM_CH  one-cycle error pulse, coincident with ch_done.
- cmd_valid  out  1  command to engine valid.
- cmd_ready  in  1  engine accepts command.
- cmd_src  out  ADDR_WIDTH  latched source address.
- cmd_dst  out  ADDR_WIDTH  latched destination address.
- cmd_len  out  LEN_WIDTH  latched length.
- eng_done  in  1  engine completion pulse.
- eng_err  in  1  engine error (BRESP/RRESP not OKAY); qualified by eng_done.
- eng_abort  out  1  one-cycle abort pulse on timeout.
- busy  out  1  high in every state except IDLE.
- active_ch  out  $clog2(NUM_CH)  channel currently owning the engine.

Behaviour:
- States: IDLE, ISSUE, WAIT, DONE.
- Reset (async, reset_n=0):
  - state=IDLE, rr_ptr=0, timeout counter=0.
  - cmd_valid=0, cmd_src/dst/len=0, eng_abort=0, ch_done=0, ch_err=0, busy=0, active_ch=0.
  - req_ready is 0 while reset_n=0.
- Arbitration in IDLE:
  - Winner = first i with req_valid[i], scanning from rr_ptr upward with wrap to 0.
  - req_ready = onehot(winner), only when state==IDLE; decoded combinationally from state, req_valid and rr_ptr.
  - No combinational path from any engine input to req_ready.
- Accept at cycle T (req_valid&req_ready):
  - Latch src/dst/len and active_ch.
  - len==0: go to DONE, no engine command, ch_err=0.
  - Otherwise: go to ISSUE; cmd_valid=1 from T+1.
- ISSUE: cmd_valid and cmd_* held stable until cmd_ready; on handshake go to WAIT, cmd_valid=0 next cycle, counter cleared.
- WAIT:
  - Counter increments each cycle.
  - eng_done: go to DONE, err_latched=eng_err.
  - Counter reaches TIMEOUT_CYCLES-1 without eng_done: eng_abort=1 for one cycle, err_latched=1, go to DONE.
  - If eng_done and timeout occur in the same cycle, eng_done wins: no abort, err_latched=eng_err.
- DONE (one cycle):
  - ch_done[active_ch]=1, ch_err[active_ch]=err_latched.
  - rr_ptr=(active_ch+1) mod NUM_CH; go to IDLE.
- Latency:
  - Accept at T gives cmd_valid at T+1.
  - eng_done at E gives ch_done at E+1; next req_ready possible at E+2.
  - Zero-length accept at T gives ch_done at T+1.
- eng_done outside WAIT is ignored.
- Requests arriving while busy remain pending; they are not lost, since requesters hold valid.
- reset_n deasserted mid-transfer: immediate return to reset values; the in-flight command is dropped and no ch_done is issued.

Decomposition:
- Package axi_dma_pkg:
  - sched_state_e enum.
  - OKAY/SLVERR/DECERR response constants.
  - Default ADDR_WIDTH/LEN_WIDTH constants.
- One sub-module rr_arbiter (NUM_CH, req vector and rr_ptr in; one-hot grant and index out), purely combinational.
- FSM, latches and counter stay in axi_dma_chan_sched.

Test Plan:
- Single request: ch1 src=0x1000 dst=0x2000 len=0x40; cmd_ready=1; eng_done 5 cycles after cmd. Expect cmd_src=0x1000, cmd_dst=0x2000, cmd_len=0x40; ch_done[1] one cycle after eng_done; ch_err=0; busy low after.
- Round-robin: ch0..ch3 all valid continuously, 3 transfers each. Expect grant order 0,1,2,3,0,1,2,3,...; no channel granted twice in a row.
- Backpressure: cmd_ready low for 7 cycles. Expect cmd_valid high and cmd_* stable for all 8 cycles; single handshake.
- Engine error: eng_done=1 with eng_err=1 on ch2. Expect ch_done[2]=1 and ch_err[2]=1 in the same cycle; rr_ptr=3.
- Timeout: TIMEOUT_CYCLES=16, eng_done never asserted. Expect eng_abort pulse 16 cycles after cmd handshake, then ch_err[active]; done-and-timeout same-cycle case gives no abort.
- Zero length and reset: ch0 len=0 gives ch_done[0] at T+1 and cmd_valid never asserted. Then reset_n low during WAIT gives all outputs reset, no ch_done.
